// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle for the shared binary-to-BCD converter.
// Two requesters on one side, per-channel BCD results on the other.
interface bcd_conv_sched_if;
  logic [1:0]  req;
  logic [7:0]  num0;
  logic [7:0]  num1;
  logic [1:0]  clr;
  logic [1:0]  ack;
  logic [11:0] bcd0;
  logic [11:0] bcd1;
  logic [1:0]  valid;
  logic        busy;

  modport master (
    output req, num0, num1, clr,
    input  ack, bcd0, bcd1, valid, busy
  );

  modport slave (
    input  req, num0, num1, clr,
    output ack, bcd0, bcd1, valid, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared fixed-latency shift-add-3 binary-to-BCD converter.
// Two 8-bit requesters, round-robin arbitration, per-channel results.
module bcd_conv_sched #(
  parameter int STEPS = 8
) (
  input logic             CLOCK_50,
  input logic             res,
  bcd_conv_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [19:0] r_sh;
  logic [3:0]  r_step;
  logic        r_g;
  logic        r_last;
  logic [1:0]  r_ack;
  logic [1:0]  r_valid;
  logic [11:0] r_bcd0;
  logic [11:0] r_bcd1;
  logic        r_busy;

  logic [1:0]  w_req;
  logic        w_any;
  logic        w_gnt;
  logic [11:0] w_adj;
  logic [19:0] w_shift;
  logic        w_abort;

  function automatic logic [3:0] f_add3(
    input logic [3:0] d
  );
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // A channel being cleared cannot win arbitration on that edge.
  assign w_req = bus.req & ~bus.clr;
  assign w_any = |w_req;
  assign w_gnt = (&w_req) ? ~r_last : w_req[1];

  assign w_adj = {
    f_add3(r_sh[19:16]),
    f_add3(r_sh[15:12]),
    f_add3(r_sh[11:8])
  };
  assign w_shift = {w_adj, r_sh[7:0]} << 1;

  assign w_abort = bus.clr[r_g] && (r_state != S_IDLE);

  // Arbitration, iterative conversion and result registers.
  always_ff @(posedge CLOCK_50 or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_step  <= '0;
      r_g     <= 1'b0;
      r_last  <= 1'b1;
      r_ack   <= '0;
      r_valid <= '0;
      r_bcd0  <= '0;
      r_bcd1  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_any) begin
              r_sh    <= {12'h000,
                          w_gnt ? bus.num1 : bus.num0};
              r_g     <= w_gnt;
              r_step  <= '0;
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
            end
          end
          S_SHIFT: begin
            r_sh   <= w_shift;
            r_step <= r_step + 4'd1;
            if (r_step == 4'(STEPS - 1))
              r_state <= S_DONE;
          end
          S_DONE: begin
            if (r_g) r_bcd1 <= r_sh[19:8];
            else     r_bcd0 <= r_sh[19:8];
            r_valid[r_g] <= 1'b1;
            r_ack[r_g]   <= 1'b1;
            r_last  <= r_g;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
      if (bus.clr[0]) begin
        r_bcd0     <= '0;
        r_valid[0] <= 1'b0;
      end
      if (bus.clr[1]) begin
        r_bcd1     <= '0;
        r_valid[1] <= 1'b0;
      end
    end
  end

  assign bus.ack   = r_ack;
  assign bus.bcd0  = r_bcd0;
  assign bus.bcd1  = r_bcd1;
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Shares one iterative binary-to-BCD converter (shift-add-3, 8 steps) between two 8-bit requesters, e.g. the switch-loaded task number and a free-running counter.
- Round-robin arbitration with a req/ack handshake.
- Keeps a per-channel registered BCD result and valid flag that drive 7-segment decoders directly.
- Replaces per-value counting converters, whose latency depends on the operand value, with a fixed-latency shared unit.

Parameters:
- STEPS, 8, number of shift-add iterations; equals the operand width; fixed at 8 for 3-digit output.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- res  input  1  reset, asynchronous, active-high; clears every register.
- req  input  2  per-channel request level; bit i belongs to channel i.
- num0  input  8  channel 0 binary operand.
- num1  input  8  channel 1 binary operand.
- clr  input  2  per-channel synchronous clear of result/valid; aborts that channel's in-flight conversion.
- ack  output  2  one-cycle pulse per channel; the result for that channel has just been written.
- bcd0  output  12  channel 0 result {hundreds, tens, ones}.
- bcd1  output  12  channel 1 result, same format.
- valid  output  2  sticky flag per channel: the result register holds a completed conversion.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset values (res high, async):
  - state=IDLE, ack=0, bcd0=bcd1=0, valid=0, busy=0.
  - step counter=0, shift register=0.
  - last_served=1, so channel 0 wins the first tie.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Only req[0] high: grant 0. Only req[1] high: grant 1.
  - Both high: grant the channel != last_served.
  - On the grant edge: capture the granted operand into shift register {bcd[11:0], bin[7:0]} = {12'h000, numX}, latch the grant index, step=0, go to SHIFT.
  - Operand changes after the grant edge are ignored.
- SHIFT, each edge:
  - Every BCD nibble >=5 gets +3, then the whole 20-bit register shifts left by 1, and step increments.
  - After the 8th step, go to DONE.
- DONE, one edge:
  - Write bcd of the granted channel = shift register [19:8] and set valid[g]=1.
  - ack[g]=1 for exactly one cycle; last_served=g; go to IDLE.
- Latency: ack[g] is registered high starting 9 rising edges after the grant edge. One conversion occupies 10 cycles including the IDLE arbitration cycle.
- A requester keeping req high after ack is a fresh request:
  - If the other channel is pending, it waits one turn. Continuous requests on both channels alternate 0,1,0,1.
- req dropped after grant: the conversion still completes, the result is written and ack pulses.
- clr[i]:
  - Next edge: bcd_i=0, valid[i]=0.
  - If channel i is granted and state is SHIFT/DONE, abort: state=IDLE, no ack, no write, last_served unchanged.
  - clr[i] wins over a same-edge DONE write for channel i.
  - clr of the non-granted channel does not disturb the running conversion.
  - clr[i] together with an IDLE grant to i: grant suppressed that cycle.
- Arithmetic: max operand 255 -> 12'h255; the hundreds nibble never exceeds 2. No overflow case exists.
- res asserted mid-conversion: immediate return to reset values. No ack is ever produced for the aborted conversion.
- busy: registered, equals (state != IDLE).

Test Plan:
- Reset, then req=2'b01, num0=173 held -> ack[0] pulses once 9 edges after grant; bcd0=12'h173, valid=2'b01; bcd1 stays 0.
- Both req high from reset, num0=255, num1=0 -> channel 0 served first (bcd0=12'h255), then channel 1 (bcd1=12'h000); 20 cycles total; valid=2'b11.
- Both req held high for 4 conversions, num0=9, num1=99 -> ack sequence 0,1,0,1; bcd0=12'h009, bcd1=12'h099; no cycle with ack=2'b11.
- Grant channel 1 with num1=100, change num1 to 42 on the next cycle -> bcd1=12'h100.
- Grant channel 0, pulse clr[0] at step 4 -> no ack[0], bcd0=0, valid[0]=0, busy low the following cycle; a pending req[1] is granted next.
- Assert res for 1 cycle during SHIFT -> all outputs 0 immediately; after release, req[0] with num0=50 gives bcd0=12'h050 with normal latency.
